device_router: RTL and testbench

- Sits directly downstream of the multi-core device arbiter and takes its single serialized device-master request.
- Decodes address bits [XLEN-1:XLEN-8] and routes each request to one of N_SLAVES memory-mapped device slaves (UART, CLINT, SPI, GPIO, ...).
- Returns the selected slave's read data and ready to the arbiter.
- Unmapped addresses and slaves that never answer (watchdog timeout) still get a response, so the arbiter FSM can never hang.

---
 rtl/device_router_pkg.sv | 25 ++
 rtl/device_addr_decode.sv | 30 +++
 rtl/device_router.sv | 134 +++++++++++++
 tb/tb_device_router.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/device_router_pkg.sv
// Shared definitions for the device router: slave tag map, FSM encoding,
// watchdog default and the select-index width helper.
package device_router_pkg;

  localparam logic [7:0] TAG_UART  = 8'hC0;
  localparam logic [7:0] TAG_CLINT = 8'hC2;
  localparam logic [7:0] TAG_SPI   = 8'hC4;
  localparam logic [7:0] TAG_GPIO  = 8'hC6;

  localparam logic [31:0] DEF_SLV_TAGS   = {TAG_GPIO, TAG_SPI, TAG_CLINT, TAG_UART};
  localparam int unsigned DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // A one-slave build still needs a 1-bit select index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/device_addr_decode.sv
// Combinational top-byte decoder: tag -> {hit, slave index}. Lowest index
// wins if tags collide.
module device_addr_decode
  import device_router_pkg::*;
#(
  parameter int                      N_SLAVES = 4,
  parameter logic [N_SLAVES*8-1:0]   SLV_TAGS = DEF_SLV_TAGS,
  parameter int                      SEL_W    = sel_width(N_SLAVES)
) (
  input  logic [7:0]       tag,
  output logic             hit,
  output logic [SEL_W-1:0] sel
);

  logic [N_SLAVES-1:0] match;

  for (genvar j = 0; j < N_SLAVES; j++) begin : g_match
    assign match[j] = (tag == SLV_TAGS[j*8 +: 8]);
  end

  // Walk high to low so the lowest matching index is the last write.
  always_comb begin
    hit = |match;
    sel = '0;
    for (int j = N_SLAVES - 1; j >= 0; j--) begin
      if (match[j]) sel = SEL_W'(j);
    end
  end

endmodule

// File: rtl/device_router.sv
// Routes the arbiter's serialized device request to one memory-mapped slave
// and always returns a response (unmapped and watchdog timeout included).
module device_router
  import device_router_pkg::*;
#(
  parameter int                    XLEN           = 32,
  parameter int                    N_SLAVES       = 4,
  parameter logic [N_SLAVES*8-1:0] SLV_TAGS       = DEF_SLV_TAGS,
  parameter int unsigned           TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter logic [XLEN-1:0]       ERR_DATA       = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m_strobe_i,
  input  logic [XLEN-1:0]          m_addr_i,
  input  logic                     m_rw_i,
  input  logic [XLEN/8-1:0]        m_byte_enable_i,
  input  logic [XLEN-1:0]          m_data_i,
  output logic                     m_data_ready_o,
  output logic [XLEN-1:0]          m_data_o,
  output logic [N_SLAVES-1:0]      s_strobe_o,
  output logic [XLEN-1:0]          s_addr_o,
  output logic                     s_rw_o,
  output logic [XLEN/8-1:0]        s_byte_enable_o,
  output logic [XLEN-1:0]          s_data_o,
  input  logic [N_SLAVES-1:0]      s_data_ready_i,
  input  logic [N_SLAVES*XLEN-1:0] s_data_i,
  output logic                     err_o,
  output logic                     overrun_o
);

  localparam int         SEL_W    = sel_width(N_SLAVES);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [SEL_W-1:0] sel_q, dec_sel;
  logic             hit_q, dec_hit;
  logic [7:0]       timer;
  logic             sel_rdy;
  logic [XLEN-1:0]  sel_data;

  device_addr_decode #(
    .N_SLAVES (N_SLAVES),
    .SLV_TAGS (SLV_TAGS),
    .SEL_W    (SEL_W)
  ) u_decode (
    .tag (m_addr_i[XLEN-1 -: 8]),
    .hit (dec_hit),
    .sel (dec_sel)
  );

  // Only the latched slave's ready/data are visible to the FSM.
  always_comb begin
    sel_rdy  = 1'b0;
    sel_data = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      if (SEL_W'(j) == sel_q) begin
        sel_rdy  = s_data_ready_i[j];
        sel_data = s_data_i[j*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      sel_q           <= '0;
      hit_q           <= 1'b0;
      timer           <= '0;
      m_data_ready_o  <= 1'b0;
      m_data_o        <= '0;
      s_strobe_o      <= '0;
      s_addr_o        <= '0;
      s_rw_o          <= 1'b0;
      s_byte_enable_o <= '0;
      s_data_o        <= '0;
      err_o           <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      s_strobe_o     <= '0;
      m_data_ready_o <= 1'b0;
      err_o          <= 1'b0;
      // Upstream must never strobe while a transaction is in flight.
      if (m_strobe_i && state != ST_IDLE) overrun_o <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (m_strobe_i) begin
            s_addr_o        <= m_addr_i;
            s_rw_o          <= m_rw_i;
            s_byte_enable_o <= m_byte_enable_i;
            s_data_o        <= m_data_i;
            sel_q           <= dec_sel;
            hit_q           <= dec_hit;
            if (dec_hit) s_strobe_o <= N_SLAVES'(1) << dec_sel;
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          if (!hit_q) begin
            m_data_o       <= ERR_DATA;
            err_o          <= 1'b1;
            m_data_ready_o <= 1'b1;
            state          <= ST_RESP;
          end else if (sel_rdy) begin
            m_data_o       <= sel_data;
            m_data_ready_o <= 1'b1;
            state          <= ST_RESP;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sel_rdy) begin
            m_data_o       <= sel_data;
            m_data_ready_o <= 1'b1;
            state          <= ST_RESP;
          end else if (timer == TMO_LAST) begin
            m_data_o       <= ERR_DATA;
            err_o          <= 1'b1;
            m_data_ready_o <= 1'b1;
            state          <= ST_RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_device_router.sv
// Directed bench for device_router: expected responses are queued at issue
// time and popped when m_data_ready_o pulses.
module tb_device_router;

  localparam int XLEN = 32;
  localparam int NS   = 4;
  localparam int TMO  = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             m_strobe_i;
  logic [XLEN-1:0]  m_addr_i;
  logic             m_rw_i;
  logic [3:0]       m_byte_enable_i;
  logic [XLEN-1:0]  m_data_i;
  logic             m_data_ready_o;
  logic [XLEN-1:0]  m_data_o;
  logic [NS-1:0]    s_strobe_o;
  logic [XLEN-1:0]  s_addr_o;
  logic             s_rw_o;
  logic [3:0]       s_byte_enable_o;
  logic [XLEN-1:0]  s_data_o;
  logic [NS-1:0]    s_data_ready_i;
  logic [NS*XLEN-1:0] s_data_i;
  logic             err_o;
  logic             overrun_o;

  device_router #(
    .XLEN           (XLEN),
    .N_SLAVES       (NS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .m_strobe_i      (m_strobe_i),
    .m_addr_i        (m_addr_i),
    .m_rw_i          (m_rw_i),
    .m_byte_enable_i (m_byte_enable_i),
    .m_data_i        (m_data_i),
    .m_data_ready_o  (m_data_ready_o),
    .m_data_o        (m_data_o),
    .s_strobe_o      (s_strobe_o),
    .s_addr_o        (s_addr_o),
    .s_rw_o          (s_rw_o),
    .s_byte_enable_o (s_byte_enable_o),
    .s_data_o        (s_data_o),
    .s_data_ready_i  (s_data_ready_i),
    .s_data_i        (s_data_i),
    .err_o           (err_o),
    .overrun_o       (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] data;
    logic            err;
    int              lat;
    bit              chk_data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   t0;

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave(input int j, input logic rdy, input logic [XLEN-1:0] d);
    s_data_ready_i    = '0;
    s_data_ready_i[j] = rdy;
    s_data_i          = '0;
    s_data_i[j*XLEN +: XLEN] = d;
  endtask

  // Drive a one-cycle strobe in cycle t and queue its expected response;
  // returns in cycle t+1.
  task automatic issue(input logic [XLEN-1:0] a, input logic rw, input logic [3:0] be,
                       input logic [XLEN-1:0] d, input logic [XLEN-1:0] ed,
                       input logic ee, input int lat, input bit cd);
    exp_t e;
    m_strobe_i = 1'b1; m_addr_i = a; m_rw_i = rw; m_byte_enable_i = be; m_data_i = d;
    e.data = ed; e.err = ee; e.lat = lat; e.chk_data = cd;
    sb.push_back(e);
    t0 = cyc;
    step();
    m_strobe_i = 1'b0;
  endtask

  task automatic expect_resp(input string tag);
    exp_t e;
    int   n = 0;
    while (m_data_ready_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, 64'(m_data_ready_o), 64'd1);
    if (m_data_ready_o === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 64'(cyc - t0), 64'(e.lat));
      if (e.chk_data) chk({tag, "_data"}, 64'(m_data_o), 64'(e.data));
      chk({tag, "_err"}, 64'(err_o), 64'(e.err));
      step();
      chk({tag, "_pulse"}, 64'({m_data_ready_o, err_o}), 64'd0);
    end
  endtask

  initial begin
    rst_i = 1'b1; m_strobe_i = 1'b0; m_addr_i = '0; m_rw_i = 1'b0;
    m_byte_enable_i = '0; m_data_i = '0; s_data_ready_i = '0; s_data_i = '0;
    step(); step();
    chk("rst_outs", 64'({m_data_ready_o, err_o, overrun_o, s_strobe_o, s_rw_o}), 64'd0);
    chk("rst_mdata", 64'(m_data_o), 64'd0);
    chk("rst_saddr", 64'(s_addr_o), 64'd0);
    rst_i = 1'b0;
    step();

    // Read slave 0, ready three cycles after its strobe.
    issue(32'hC000_0004, 1'b0, 4'hF, 32'h0, 32'h41, 1'b0, 5, 1'b1);
    chk("rd_strobe", 64'(s_strobe_o), 64'b0001);
    chk("rd_addr", 64'(s_addr_o), 64'hC000_0004);
    chk("rd_rw", 64'(s_rw_o), 64'd0);
    step(); step(); step();
    chk("rd_strobe_off", 64'(s_strobe_o), 64'd0);
    slave(0, 1'b1, 32'h41);
    step();
    slave(0, 1'b0, 32'h0);
    expect_resp("rd");
    step(); step();

    // Write slave 1, ready in the issue cycle.
    issue(32'hC200_0000, 1'b1, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 2, 1'b0);
    chk("wr_strobe", 64'(s_strobe_o), 64'b0010);
    chk("wr_sdata", 64'(s_data_o), 64'h1234_5678);
    chk("wr_rw", 64'(s_rw_o), 64'd1);
    chk("wr_be", 64'(s_byte_enable_o), 64'hF);
    slave(1, 1'b1, 32'hAAAA_AAAA);
    step();
    slave(1, 1'b0, 32'h0);
    expect_resp("wr");
    step(); step();

    // Unmapped address.
    issue(32'h8000_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 2, 1'b1);
    chk("um_strobe", 64'(s_strobe_o), 64'd0);
    expect_resp("um");
    step(); step();

    // Slave 2 never answers; stray ready from slave 3 while waiting.
    issue(32'hC400_0010, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, TMO + 2, 1'b1);
    chk("to_strobe", 64'(s_strobe_o), 64'b0100);
    step();
    slave(3, 1'b1, 32'h5555_5555);
    step();
    slave(3, 1'b0, 32'h0);
    expect_resp("to");
    chk("to_no_overrun", 64'(overrun_o), 64'd0);
    step(); step();

    // Second strobe while waiting on slave 3.
    issue(32'hC600_0000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 4, 1'b1);
    chk("ov_strobe", 64'(s_strobe_o), 64'b1000);
    step();
    m_strobe_i = 1'b1; m_addr_i = 32'hC000_0000;
    step();
    m_strobe_i = 1'b0;
    chk("ov_flag", 64'(overrun_o), 64'd1);
    chk("ov_no_strobe", 64'(s_strobe_o), 64'd0);
    chk("ov_addr_hold", 64'(s_addr_o), 64'hC600_0000);
    slave(3, 1'b1, 32'hDEAD_BEEF);
    step();
    slave(3, 1'b0, 32'h0);
    expect_resp("ov");
    step(); step();
    chk("ov_sticky", 64'(overrun_o), 64'd1);
    chk("ov_no_2nd", 64'(s_strobe_o), 64'd0);

    // Reset in the middle of a wait; the late ready must be ignored.
    m_strobe_i = 1'b1; m_addr_i = 32'hC000_0008; m_rw_i = 1'b0;
    step();
    m_strobe_i = 1'b0;
    step(); step();
    rst_i = 1'b1;
    #1;
    chk("mr_outs", 64'({m_data_ready_o, err_o, overrun_o, s_strobe_o}), 64'd0);
    chk("mr_saddr", 64'(s_addr_o), 64'd0);
    chk("mr_mdata", 64'(m_data_o), 64'd0);
    step();
    rst_i = 1'b0;
    slave(0, 1'b1, 32'h77);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_quiet", 64'({m_data_ready_o, s_strobe_o}), 64'd0);
    end
    slave(0, 1'b0, 32'h0);
    step();

    issue(32'hC200_0040, 1'b0, 4'h3, 32'h0, 32'h0000_BEEF, 1'b0, 2, 1'b1);
    chk("post_strobe", 64'(s_strobe_o), 64'b0010);
    slave(1, 1'b1, 32'h0000_BEEF);
    step();
    slave(1, 1'b0, 32'h0);
    expect_resp("post");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
